// File: rtl/bt656_capture_ctrl.sv
// bt656_capture_ctrl: frame-capture sequencer for a BT.656/DVP pixel stream.
// Arms on start, waits for a frame boundary, optionally skips frames, then
// forwards active pixels with SOF/EOL markers and reports the frame geometry.
module bt656_capture_ctrl #(
  parameter int   DW        = 10,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   CNT_W     = 12,
  parameter int   SKIP_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW-1:0]     st_data_i,
  input  logic              st_href_i,
  input  logic              st_vsync_i,
  input  logic              cfg_cont_i,
  input  logic [SKIP_W-1:0] cfg_skip_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [DW-1:0]     m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_sof_o,
  output logic              m_eol_o,
  output logic              frame_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  lines_o,
  output logic [CNT_W-1:0]  ppl_o,
  output logic [15:0]       frame_cnt_o,
  output logic              line_err_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {IDLE, ARM, SKIP, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic              vs_act, vs_act_q, fb;
  logic              frame_end, start_ok, take, line_end;
  logic [SKIP_W-1:0] skip_cnt;
  logic              sof_pend;
  logic              s1_vld, s1_sof, s2_vld, s2_sof;
  logic [DW-1:0]     s1_data, s2_data;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, ref_ppl;
  logic [CNT_W-1:0]  lines_eff, ppl_eff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Normalise VSYNC so 1 always means "in vertical blanking".
  assign vs_act = st_vsync_i ^ ~VSYNC_POL;
  assign fb     = vs_act & ~vs_act_q;

  // A pixel is taken only while capturing, HREF high and outside VSYNC.
  assign take     = (state_q == CAPTURE) & st_href_i & ~vs_act & ~abort_i;
  // Stage1 held a pixel and the current cycle brings none: captured HREF fell.
  assign line_end = (state_q == CAPTURE) & s1_vld & ~take & ~abort_i;
  assign start_ok = (state_q == IDLE) & start_i & ~abort_i;

  // Geometry as it stands once a line still open at this cycle is closed.
  assign lines_eff = line_end ? sat_inc(line_cnt) : line_cnt;
  assign ppl_eff   = (line_cnt != '0) ? ref_ppl : (line_end ? pix_cnt : '0);

  // VSYNC history for boundary detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vs_act_q <= 1'b0;
    else       vs_act_q <= vs_act;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition and suppresses the report.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = ARM;
      ARM:     if (fb) state_d = (cfg_skip_i == '0) ? CAPTURE : SKIP;
      SKIP:    if (fb && skip_cnt <= SKIP_W'(1)) state_d = CAPTURE;
      CAPTURE: if (fb) begin
                 frame_end = 1'b1;
                 if (!cfg_cont_i) state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d   = IDLE;
      frame_end = 1'b0;
    end
  end

  // Frames still to discard; loaded at the arming boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         skip_cnt <= '0;
    else if (state_q == ARM && fb)     skip_cnt <= cfg_skip_i;
    else if (state_q == SKIP && fb)    skip_cnt <= skip_cnt - 1'b1;
  end

  // SOF is owed to the first pixel after every boundary that leads into capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              sof_pend <= 1'b0;
    else if (abort_i)                       sof_pend <= 1'b0;
    else if (fb && state_d == CAPTURE)      sof_pend <= 1'b1;
    else if (take)                          sof_pend <= 1'b0;
  end

  // Two-stage output pipeline; abort empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      s1_sof  <= 1'b0;
      s1_data <= '0;
      s2_vld  <= 1'b0;
      s2_sof  <= 1'b0;
      s2_data <= '0;
    end else if (abort_i) begin
      s1_vld  <= 1'b0;
      s1_sof  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_sof  <= 1'b0;
    end else begin
      s1_vld  <= take;
      s1_sof  <= take & sof_pend;
      s1_data <= st_data_i;
      s2_vld  <= s1_vld;
      s2_sof  <= s1_sof;
      s2_data <= s1_data;
    end
  end

  assign m_data_o  = s2_data;
  assign m_valid_o = s2_vld;
  assign m_sof_o   = s2_vld & s2_sof;
  assign m_eol_o   = s2_vld & ~s1_vld;
  assign busy_o    = (state_q != IDLE);

  // Per-frame pixel/line counters; every boundary starts a fresh frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      ref_ppl  <= '0;
    end else if (abort_i || fb) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      ref_ppl  <= '0;
    end else begin
      if (take) pix_cnt <= sat_inc(pix_cnt);
      if (line_end) begin
        pix_cnt  <= '0;
        line_cnt <= sat_inc(line_cnt);
        if (line_cnt == '0) ref_ppl <= pix_cnt;
      end
    end
  end

  // Sticky line-length error; cleared when a new capture is armed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                                line_err_o <= 1'b0;
    else if (start_ok)                                        line_err_o <= 1'b0;
    else if (line_end && line_cnt != '0 && pix_cnt != ref_ppl) line_err_o <= 1'b1;
  end

  // Sticky overflow: a pixel was presented while downstream was not ready.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        ovf_o <= 1'b0;
    else if (start_ok)                ovf_o <= 1'b0;
    else if (s2_vld && !m_ready_i)    ovf_o <= 1'b1;
  end

  // End-of-frame report.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_done_o <= 1'b0;
      lines_o      <= '0;
      ppl_o        <= '0;
      frame_cnt_o  <= '0;
    end else begin
      frame_done_o <= frame_end;
      if (frame_end) begin
        lines_o     <= lines_eff;
        ppl_o       <= ppl_eff;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Randomized bench for bt656_capture_ctrl: frames are described as lists of
// line lengths; the expected pixel stream and frame reports come from those lists.
module tb_bt656_capture_ctrl;
  localparam int DW = 10, CNT_W = 12, SKIP_W = 4;

  logic              clk = 1'b0, rst = 1'b0;
  logic [DW-1:0]     st_data = '0;
  logic              st_href = 1'b0, st_vsync = 1'b0;
  logic              cfg_cont = 1'b0;
  logic [SKIP_W-1:0] cfg_skip = '0;
  logic              start = 1'b0, abort = 1'b0, m_ready = 1'b1;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_sof, m_eol, frame_done, busy, line_err, ovf;
  logic [CNT_W-1:0]  lines, ppl;
  logic [15:0]       frame_cnt;

  bt656_capture_ctrl #(.DW(DW), .VSYNC_POL(1'b1), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut (
    .clk_i(clk), .rst_i(rst), .st_data_i(st_data), .st_href_i(st_href),
    .st_vsync_i(st_vsync), .cfg_cont_i(cfg_cont), .cfg_skip_i(cfg_skip),
    .start_i(start), .abort_i(abort), .m_data_o(m_data), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_sof_o(m_sof), .m_eol_o(m_eol), .frame_done_o(frame_done),
    .busy_o(busy), .lines_o(lines), .ppl_o(ppl), .frame_cnt_o(frame_cnt),
    .line_err_o(line_err), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic sof; logic eol; logic [DW-1:0] d; } beat_t;
  typedef struct packed { logic [CNT_W-1:0] lines; logic [CNT_W-1:0] ppl; logic [15:0] fc; } rep_t;

  beat_t exp_q[$], got_q[$];
  rep_t  got_r[$];
  beat_t mb;
  rep_t  mr;
  int    n_pass = 0, n_total = 0;
  int    exp_fcnt = 0;
  bit    cap_now = 0, first_pix = 0;
  int    fr_lens[$];

  // Record every presented beat and every frame report.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        mb = '{sof: m_sof, eol: m_eol, d: m_data};
        got_q.push_back(mb);
      end
      if (frame_done) begin
        mr = '{lines: lines, ppl: ppl, fc: frame_cnt};
        got_r.push_back(mr);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_r.delete();
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Vertical blanking with HREF noise that must be ignored.
  task automatic send_vsync();
    st_vsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_href = 1'($urandom_range(0, 1));
      st_data = DW'($urandom_range(0, 1023));
      tick();
    end
    st_vsync = 1'b0; st_href = 1'b0;
    tick(); tick();
  endtask

  // One active line; rdy_low selects a pixel slot during which ready drops.
  task automatic send_line(input int len, input int rdy_low);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      st_href = 1'b1;
      st_data = DW'($urandom_range(0, 1023));
      m_ready = (j == rdy_low) ? 1'b0 : 1'b1;
      if (cap_now) begin
        b = '{sof: first_pix, eol: (j == len - 1), d: st_data};
        exp_q.push_back(b);
        first_pix = 0;
      end
      tick();
    end
    st_href = 1'b0; m_ready = 1'b1;
    tick(); tick();
  endtask

  // Whole frame from fr_lens: opening boundary then lines.
  task automatic send_frame(input bit cap);
    send_vsync();
    cap_now = cap; first_pix = cap;
    foreach (fr_lens[i]) send_line(fr_lens[i], -1);
    cap_now = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_total++;
    if ({busy, m_valid, m_sof, m_eol, frame_done, line_err, ovf, lines, ppl, frame_cnt} !== '0)
      $display("FAIL reset_outputs: got busy=%b valid=%b fc=%0d lines=%0d ppl=%0d expected all 0",
               busy, m_valid, frame_cnt, lines, ppl);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    int bad, nsof, neol;
    clear_q();
    cfg_cont = 0; cfg_skip = 0;
    do_start();
    n_total++;
    if (busy !== 1'b1) $display("FAIL single_armed: busy=%b expected 1", busy); else n_pass++;
    fr_lens = '{8, 8, 8, 8};
    send_frame(1);
    send_vsync();
    repeat (3) tick();
    exp_fcnt++;
    bad = 0; nsof = 0; neol = 0;
    foreach (got_q[i]) begin
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) bad++;
      nsof += got_q[i].sof; neol += got_q[i].eol;
    end
    n_total++;
    if (got_q.size() != 32) $display("FAIL single_pixels: got %0d expected 32", got_q.size()); else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL single_stream: %0d beats differ, expected 0", bad); else n_pass++;
    n_total++;
    if (nsof != 1 || !got_q[0].sof) $display("FAIL single_sof: count %0d expected 1 on first beat", nsof); else n_pass++;
    n_total++;
    if (neol != 4) $display("FAIL single_eol: count %0d expected 4", neol); else n_pass++;
    n_total++;
    if (got_r.size() != 1) $display("FAIL single_done: %0d pulses expected 1", got_r.size());
    else if (got_r[0] !== rep_t'{lines: 4, ppl: 8, fc: 16'(exp_fcnt)})
      $display("FAIL single_report: lines=%0d ppl=%0d fc=%0d expected 4/8/%0d",
               got_r[0].lines, got_r[0].ppl, got_r[0].fc, exp_fcnt);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || line_err !== 1'b0 || ovf !== 1'b0)
      $display("FAIL single_after: busy=%b err=%b ovf=%b expected 0/0/0", busy, line_err, ovf);
    else n_pass++;
  endtask

  task automatic test_skip_cont();
    rep_t exp_r[$];
    int bad, nl, pl;
    clear_q();
    cfg_cont = 1; cfg_skip = 2;
    do_start();
    send_vsync();                               // arming boundary
    for (int k = 1; k <= 4; k++) begin
      nl = $urandom_range(2, 4); pl = $urandom_range(3, 9);
      fr_lens.delete();
      for (int i = 0; i < nl; i++) fr_lens.push_back(pl);
      cap_now = (k > 2); first_pix = cap_now;
      foreach (fr_lens[i]) send_line(fr_lens[i], -1);
      cap_now = 0;
      send_vsync();                             // closes frame k
      if (k > 2) begin
        exp_fcnt++;
        exp_r.push_back(rep_t'{lines: CNT_W'(nl), ppl: CNT_W'(pl), fc: 16'(exp_fcnt)});
      end
    end
    repeat (3) tick();
    bad = 0;
    foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) bad++;
    n_total++;
    if (got_q.size() != exp_q.size()) $display("FAIL skip_pixels: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL skip_stream: %0d beats differ, expected 0", bad); else n_pass++;
    n_total++;
    if (got_r.size() != 2) $display("FAIL skip_done: %0d pulses expected 2", got_r.size()); else n_pass++;
    for (int i = 0; i < 2 && i < got_r.size(); i++) begin
      n_total++;
      if (got_r[i] !== exp_r[i])
        $display("FAIL skip_report%0d: lines=%0d ppl=%0d fc=%0d expected %0d/%0d/%0d", i,
                 got_r[i].lines, got_r[i].ppl, got_r[i].fc, exp_r[i].lines, exp_r[i].ppl, exp_r[i].fc);
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL skip_busy: busy=%b expected 1", busy); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL skip_stop: busy=%b expected 0", busy); else n_pass++;
    cfg_cont = 0; cfg_skip = 0;
  endtask

  task automatic test_ovf();
    int bad, r;
    clear_q();
    r = $urandom_range(2, 7);
    do_start();
    send_vsync();
    cap_now = 1; first_pix = 1;
    send_line(8, -1); send_line(8, r); send_line(8, -1); send_line(8, -1);
    cap_now = 0;
    send_vsync();
    repeat (3) tick();
    exp_fcnt++;
    bad = 0;
    foreach (got_q[i]) if (i < exp_q.size() && got_q[i] !== exp_q[i]) bad++;
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_flag: ovf=%b expected 1", ovf); else n_pass++;
    n_total++;
    if (got_q.size() != 32 || bad != 0)
      $display("FAIL ovf_stream: %0d beats (%0d differ) expected 32 (0)", got_q.size(), bad);
    else n_pass++;
    n_total++;
    if (got_r.size() != 1 || lines !== 12'd4 || ppl !== 12'd8)
      $display("FAIL ovf_geometry: pulses=%0d lines=%0d ppl=%0d expected 1/4/8", got_r.size(), lines, ppl);
    else n_pass++;
  endtask

  task automatic test_line_err();
    bit err_exp;
    clear_q();
    do_start();
    n_total++;
    if (ovf !== 1'b0 || line_err !== 1'b0)
      $display("FAIL start_clear: ovf=%b err=%b expected 0/0", ovf, line_err);
    else n_pass++;
    fr_lens = '{8, 8, 7, 8};
    err_exp = 0;
    foreach (fr_lens[i]) if (fr_lens[i] != fr_lens[0]) err_exp = 1;
    send_frame(1);
    send_vsync();
    repeat (3) tick();
    exp_fcnt++;
    n_total++;
    if (line_err !== err_exp) $display("FAIL lerr_flag: err=%b expected %b", line_err, err_exp); else n_pass++;
    n_total++;
    if (lines !== 12'd4 || ppl !== 12'(fr_lens[0]) || frame_cnt !== 16'(exp_fcnt))
      $display("FAIL lerr_report: lines=%0d ppl=%0d fc=%0d expected 4/%0d/%0d", lines, ppl, frame_cnt, fr_lens[0], exp_fcnt);
    else n_pass++;
    do_start();
    n_total++;
    if (line_err !== 1'b0) $display("FAIL lerr_clear: err=%b expected 0", line_err); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_zero_lines();
    clear_q();
    do_start();
    send_vsync();
    send_vsync();
    repeat (3) tick();
    exp_fcnt++;
    n_total++;
    if (got_r.size() != 1) $display("FAIL zero_done: %0d pulses expected 1", got_r.size());
    else if (got_r[0] !== rep_t'{lines: 0, ppl: 0, fc: 16'(exp_fcnt)})
      $display("FAIL zero_report: lines=%0d ppl=%0d fc=%0d expected 0/0/%0d",
               got_r[0].lines, got_r[0].ppl, got_r[0].fc, exp_fcnt);
    else n_pass++;
    n_total++;
    if (got_q.size() != 0 || busy !== 1'b0)
      $display("FAIL zero_after: beats=%0d busy=%b expected 0/0", got_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    clear_q();
    do_start();
    send_vsync();
    send_line(8, -1);
    for (int j = 0; j < 4; j++) begin
      st_href = 1'b1; st_data = DW'($urandom_range(0, 1023)); tick();
    end
    abort = 1'b1; tick();
    n_total++;
    if (busy !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL abort_stop: busy=%b valid=%b expected 0/0", busy, m_valid);
    else n_pass++;
    abort = 1'b0; st_href = 1'b0;
    repeat (2) tick();
    send_vsync();
    repeat (3) tick();
    n_total++;
    if (got_r.size() != 0 || frame_cnt !== 16'(exp_fcnt))
      $display("FAIL abort_report: pulses=%0d fc=%0d expected 0/%0d", got_r.size(), frame_cnt, exp_fcnt);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    clear_q();
    do_start();
    send_vsync();
    send_line(8, -1);
    for (int j = 0; j < 4; j++) begin
      st_href = 1'b1; st_data = DW'($urandom_range(0, 1023)); tick();
    end
    n_total++;
    if (m_valid !== 1'b1) $display("FAIL arst_midline: valid=%b expected 1", m_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({busy, m_valid, m_sof, m_eol, frame_done, line_err, ovf, lines, ppl, frame_cnt} !== '0)
      $display("FAIL arst_outputs: busy=%b valid=%b fc=%0d lines=%0d expected all 0", busy, m_valid, frame_cnt, lines);
    else n_pass++;
    st_href = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_fcnt = 0;
    clear_q();
    send_vsync();
    repeat (3) tick();
    n_total++;
    if (busy !== 1'b0 || got_r.size() != 0 || frame_cnt !== 16'(exp_fcnt))
      $display("FAIL arst_idle: busy=%b pulses=%0d fc=%0d expected 0/0/0", busy, got_r.size(), frame_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_skip_cont();
    test_ovf();
    test_line_err();
    test_zero_lines();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case a wait ever runs away.
  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
